// File: rtl/lab06_frame_driver.sv
// Frame initiator for the lab06 number-stream core: plays a latched nibble frame,
// waits for the single result beat and keeps pass/fail/timeout self-test statistics.
//
// state  | meaning
// IDLE   | waiting for start
// SEND   | one nibble beat per cycle toward the core
// WAIT   | waiting for the result beat, wait counter running
// REPORT | done pulse, statistics already updated
module lab06_frame_driver #(
    parameter int FRAME_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [4*FRAME_LEN-1:0]   frame_data,
    input  logic [1:0]               frame_mode,
    input  logic signed [5:0]        exp_result,
    output logic                     busy,
    output logic                     in_valid,
    output logic [3:0]               in_number,
    output logic [1:0]               mode,
    input  logic                     out_valid,
    input  logic signed [5:0]        out_result,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic signed [5:0]        got_result,
    output logic [7:0]               pass_cnt,
    output logic [7:0]               fail_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, REPORT} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               beat_q, beat_d;
    logic [7:0]               wait_q, wait_d;
    logic [4*FRAME_LEN-1:0]   shift_q, shift_d;
    logic signed [5:0]        exp_q, exp_d;

    logic                     busy_d, in_valid_d, done_d, pass_d, timeout_d;
    logic [3:0]               in_number_d;
    logic [1:0]               mode_d;
    logic signed [5:0]        got_d;
    logic [7:0]               pass_cnt_d, fail_cnt_d;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        shift_d     = shift_q;
        exp_d       = exp_q;
        busy_d      = busy;
        in_valid_d  = 1'b0;
        in_number_d = 4'd0;
        mode_d      = 2'd0;
        done_d      = 1'b0;
        pass_d      = pass;
        timeout_d   = timeout;
        got_d       = got_result;
        pass_cnt_d  = pass_cnt;
        fail_cnt_d  = fail_cnt;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d     = SEND;
                    beat_d      = 4'd0;
                    busy_d      = 1'b1;
                    in_valid_d  = 1'b1;
                    in_number_d = frame_data[3:0];
                    mode_d      = frame_mode;
                    shift_d     = frame_data >> 4;
                    exp_d       = exp_result;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    got_d       = 6'sd0;
                end
            end
            SEND: begin
                // Outputs always show the beat of the current cycle, so the next
                // nibble is fetched from the shift register one edge ahead.
                if (beat_q == 4'(FRAME_LEN - 1)) begin
                    state_d = WAIT;
                    wait_d  = 8'd0;
                end else begin
                    beat_d      = beat_q + 4'd1;
                    in_valid_d  = 1'b1;
                    in_number_d = shift_q[3:0];
                    shift_d     = shift_q >> 4;
                end
            end
            WAIT: begin
                if (out_valid) begin
                    state_d   = REPORT;
                    done_d    = 1'b1;
                    got_d     = out_result;
                    pass_d    = (out_result == exp_q);
                    timeout_d = 1'b0;
                    if (out_result == exp_q) begin
                        if (pass_cnt != 8'hFF) pass_cnt_d = pass_cnt + 8'd1;
                    end else begin
                        if (fail_cnt != 8'hFF) fail_cnt_d = fail_cnt + 8'd1;
                    end
                end else if (wait_q + 8'd1 == 8'(TIMEOUT)) begin
                    state_d   = REPORT;
                    done_d    = 1'b1;
                    got_d     = 6'sd0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                    if (fail_cnt != 8'hFF) fail_cnt_d = fail_cnt + 8'd1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            REPORT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= 4'd0;
            wait_q     <= 8'd0;
            shift_q    <= '0;
            exp_q      <= 6'sd0;
            busy       <= 1'b0;
            in_valid   <= 1'b0;
            in_number  <= 4'd0;
            mode       <= 2'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            got_result <= 6'sd0;
            pass_cnt   <= 8'd0;
            fail_cnt   <= 8'd0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            shift_q    <= shift_d;
            exp_q      <= exp_d;
            busy       <= busy_d;
            in_valid   <= in_valid_d;
            in_number  <= in_number_d;
            mode       <= mode_d;
            done       <= done_d;
            pass       <= pass_d;
            timeout    <= timeout_d;
            got_result <= got_d;
            pass_cnt   <= pass_cnt_d;
            fail_cnt   <= fail_cnt_d;
        end
    end

endmodule

// File: tb/tb_lab06_frame_driver.sv
// Directed bench for lab06_frame_driver: table of frames plus hand sequences for
// reset, protocol slips and counter saturation.
module tb_lab06_frame_driver;

    localparam int FL = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n, start, out_valid;
    logic [15:0] frame_data;
    logic [1:0]  frame_mode;
    logic [5:0]  exp_result, out_result;
    logic        busy, in_valid, done, pass, timeout;
    logic [3:0]  in_number;
    logic [1:0]  mode;
    logic [5:0]  got_result;
    logic [7:0]  pass_cnt, fail_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lab06_frame_driver #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_data(frame_data),
        .frame_mode(frame_mode), .exp_result(exp_result), .busy(busy),
        .in_valid(in_valid), .in_number(in_number), .mode(mode),
        .out_valid(out_valid), .out_result(out_result), .done(done),
        .pass(pass), .timeout(timeout), .got_result(got_result),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    typedef struct {
        logic [15:0] frame;
        logic [1:0]  fmode;
        logic [5:0]  exp_v;
        int          delay;   // WAIT cycle carrying out_valid, 0 = core silent
        logic [5:0]  core;
        logic        e_pass;
        logic        e_to;
        logic [5:0]  e_got;
        logic [7:0]  e_pc;
        logic [7:0]  e_fc;
    } vec_t;

    vec_t tbl[6];

    function automatic vec_t mk(input logic [15:0] f, input logic [1:0] m, input logic [5:0] e,
                                input int d, input logic [5:0] c, input logic ep, input logic et,
                                input logic [5:0] eg, input logic [7:0] pc, input logic [7:0] fc);
        vec_t v;
        v.frame = f; v.fmode = m; v.exp_v = e; v.delay = d; v.core = c;
        v.e_pass = ep; v.e_to = et; v.e_got = eg; v.e_pc = pc; v.e_fc = fc;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".busy"}, 16'(busy), 16'd0);
        check({name, ".in_valid"}, 16'(in_valid), 16'd0);
        check({name, ".in_number"}, 16'(in_number), 16'd0);
        check({name, ".mode"}, 16'(mode), 16'd0);
        check({name, ".done"}, 16'(done), 16'd0);
        check({name, ".pass"}, 16'(pass), 16'd0);
        check({name, ".timeout"}, 16'(timeout), 16'd0);
        check({name, ".got"}, 16'(got_result), 16'd0);
        check({name, ".pass_cnt"}, 16'(pass_cnt), 16'd0);
        check({name, ".fail_cnt"}, 16'(fail_cnt), 16'd0);
    endtask

    task automatic run_frame(input vec_t v);
        int   w;
        int   exp_w;
        bit   seen;
        logic [15:0] fd;
        fd = v.frame;
        frame_data = v.frame; frame_mode = v.fmode; exp_result = v.exp_v; start = 1'b1;
        step();
        // scramble the inputs so a frame that is not latched shows up
        start = 1'b0; frame_data = ~v.frame; frame_mode = ~v.fmode; exp_result = ~v.exp_v;
        for (int k = 0; k < FL; k++) begin
            check("beat.in_valid", 16'(in_valid), 16'd1);
            check("beat.busy", 16'(busy), 16'd1);
            check("beat.in_number", 16'(in_number), 16'(fd[4*k +: 4]));
            check("beat.mode", 16'(mode), (k == 0) ? 16'(v.fmode) : 16'd0);
            step();
        end
        w = 1;
        seen = 1'b0;
        while (w <= 40 && !seen) begin
            check("wait.in_valid", 16'(in_valid), 16'd0);
            check("wait.in_number", 16'(in_number), 16'd0);
            out_valid  = (w == v.delay);
            out_result = (w == v.delay) ? v.core : ~v.core;
            step();
            out_valid = 1'b0;
            w++;
            if (done) seen = 1'b1;
        end
        exp_w = (v.delay > 0 && v.delay <= TO) ? v.delay + 1 : TO + 1;
        check("done.seen", 16'(seen), 16'd1);
        check("done.wait_cycle", 16'(w), 16'(exp_w));
        check("rep.pass", 16'(pass), 16'(v.e_pass));
        check("rep.timeout", 16'(timeout), 16'(v.e_to));
        check("rep.got", 16'(got_result), 16'(v.e_got));
        check("rep.pass_cnt", 16'(pass_cnt), 16'(v.e_pc));
        check("rep.fail_cnt", 16'(fail_cnt), 16'(v.e_fc));
        check("rep.busy", 16'(busy), 16'd1);
        step();
        check("post.done", 16'(done), 16'd0);
        check("post.busy", 16'(busy), 16'd0);
        check("post.got_hold", 16'(got_result), 16'(v.e_got));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t sat;
        int   pc;

        tbl[0] = mk(16'h4321, 2'b01, 6'd10,   3, 6'd10,   1'b1, 1'b0, 6'd10,   8'd1, 8'd0);
        tbl[1] = mk(16'hA5C3, 2'b10, 6'h3B,   2, 6'h05,   1'b0, 1'b0, 6'h05,   8'd1, 8'd1);
        tbl[2] = mk(16'h0F1E, 2'b11, 6'd3,    0, 6'd3,    1'b0, 1'b1, 6'd0,    8'd1, 8'd2);
        tbl[3] = mk(16'h9B7D, 2'b01, 6'h3B,  16, 6'h3B,   1'b1, 1'b0, 6'h3B,   8'd2, 8'd2);
        tbl[4] = mk(16'h1234, 2'b00, 6'h20,   1, 6'h20,   1'b1, 1'b0, 6'h20,   8'd3, 8'd2);
        tbl[5] = mk(16'hFEDC, 2'b10, 6'd0,   15, 6'h3F,   1'b0, 1'b0, 6'h3F,   8'd3, 8'd3);

        rst_n = 1'b0; start = 1'b1; frame_data = 16'h4321; frame_mode = 2'b01;
        exp_result = 6'd10; out_valid = 1'b0; out_result = 6'd0;
        step();
        check_all_zero("rst1");
        step();
        check_all_zero("rst2");

        // start accepted on the first cycle out of reset
        rst_n = 1'b1;
        run_frame(tbl[0]);

        // reset during beat 2, then replay from nibble 0
        frame_data = 16'h4321; frame_mode = 2'b01; exp_result = 6'd10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid.beat2", 16'(in_number), 16'd3);
        rst_n = 1'b0;
        step();
        check("mid.in_valid", 16'(in_valid), 16'd0);
        check("mid.busy", 16'(busy), 16'd0);
        check("mid.pass_cnt", 16'(pass_cnt), 16'd0);
        check("mid.fail_cnt", 16'(fail_cnt), 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        // protocol slips: start and out_valid during SEND, out_valid held 3 cycles
        frame_data = 16'h4321; frame_mode = 2'b01; exp_result = 6'd7; start = 1'b1;
        step();
        check("slip.beat0", 16'(in_number), 16'd1);
        start = 1'b1; frame_data = 16'hEEEE; exp_result = 6'd9;
        out_valid = 1'b1; out_result = 6'd9;
        step();
        start = 1'b0; out_valid = 1'b0;
        check("slip.beat1", 16'(in_number), 16'd2);
        check("slip.busy1", 16'(busy), 16'd1);
        step();
        check("slip.beat2", 16'(in_number), 16'd3);
        step();
        check("slip.beat3", 16'(in_number), 16'd4);
        check("slip.mode3", 16'(mode), 16'd0);
        step();
        check("slip.wait1_valid", 16'(in_valid), 16'd0);
        check("slip.wait1_done", 16'(done), 16'd0);
        out_valid = 1'b1; out_result = 6'd7;
        step();
        check("slip.done", 16'(done), 16'd1);
        check("slip.got", 16'(got_result), 16'd7);
        check("slip.pass", 16'(pass), 16'd1);
        check("slip.pass_cnt", 16'(pass_cnt), 16'd4);
        out_result = 6'd9;
        step();
        check("slip.busy_fall", 16'(busy), 16'd0);
        check("slip.done_low", 16'(done), 16'd0);
        out_result = 6'd11;
        step();
        out_valid = 1'b0;
        check("slip.got_hold", 16'(got_result), 16'd7);
        check("slip.pass_hold", 16'(pass), 16'd1);
        check("slip.pass_cnt_hold", 16'(pass_cnt), 16'd4);
        check("slip.fail_cnt_hold", 16'(fail_cnt), 16'd3);
        check("slip.idle", 16'(busy), 16'd0);

        // saturation: 260 more passing frames
        pc = 4;
        for (int n = 0; n < 260; n++) begin
            pc = (pc < 255) ? pc + 1 : 255;
            sat = mk(16'h4321, 2'b01, 6'd10, 1, 6'd10, 1'b1, 1'b0, 6'd10, 8'(pc), 8'd3);
            run_frame(sat);
        end
        check("sat.pass_cnt", 16'(pass_cnt), 16'd255);
        check("sat.fail_cnt", 16'(fail_cnt), 16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lab06_frame_driver.md
# lab06_frame_driver

Synthesizable initiator for the lab06 number-stream interface (`in_valid` / `in_number` / `mode` → `out_valid` / `out_result`). It sits on the driving side of a lab06 computation core and replaces the behavioural pattern. On a `start` command it plays one latched frame of 4-bit numbers, with the mode attached to the first beat. It then waits for the core's single result beat, compares it against an expected value, and keeps pass/fail/timeout statistics for on-chip self-test.

## Interface
- FRAME_LEN, 4: nibbles sent per frame (2..15).
- TIMEOUT, 16: maximum WAIT cycles before a frame is declared lost (2..255).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  launch a frame; honoured only while busy=0.
- frame_data  in  4*FRAME_LEN  nibbles; bits [3:0] are sent first.
- frame_mode  in  2  mode for the frame.
- exp_result  in  6 signed  expected core result.
- busy  out  1  frame in progress.
- in_valid  out  1  beat valid toward the core.
- in_number  out  4  current nibble; 0 when in_valid=0.
- mode  out  2  frame_mode on the first beat only; 0 otherwise.
- out_valid  in  1  result beat from the core.
- out_result  in  6 signed  core result.
- done  out  1  one-cycle report pulse.
- pass  out  1  last frame matched.
- timeout  out  1  last frame timed out.
- got_result  out  6 signed  captured result; 0 on timeout.
- pass_cnt  out  8  saturating pass count.
- fail_cnt  out  8  saturating fail count (mismatch or timeout).

## Operation
- States: IDLE → SEND → WAIT → REPORT → IDLE.
- IDLE: on start=1, latch frame_data, frame_mode and exp_result, then go to SEND with the beat index at 0.
- SEND:
  - Drive beat k for one cycle each: in_valid=1 and in_number=frame_data[4k+3:4k].
  - mode=frame_mode when k=0, otherwise 0.
  - After beat FRAME_LEN-1, go to WAIT with the wait counter at 0.
- WAIT: in_valid=0, in_number=0, mode=0.
  - If out_valid=1: capture out_result and set pass=(out_result==exp_result). Go to REPORT.
  - If out_valid=0: increment the wait counter. When it reaches TIMEOUT, set timeout=1, pass=0 and got_result=0, then go to REPORT.
- REPORT: done=1 for exactly one cycle, then IDLE.
  - Counter update on the REPORT transition: pass increments pass_cnt; mismatch or timeout increments fail_cnt.
  - Both counters saturate at 255.
- pass, timeout and got_result hold from REPORT until the next accepted start, which clears them.
- Ignored inputs:
  - out_valid outside WAIT (protocol slip).
  - out_valid cycles after the first one in a frame.
  - start while busy=1.
- Comparison is a 6-bit two's-complement equality check; there is no width extension.

## Timing
- All outputs are registered. On reset, every output is 0 (busy, in_valid, in_number, mode, done, pass, timeout, got_result, pass_cnt, fail_cnt), and the state returns to IDLE.
- start sampled at edge t:
  - busy=1 and the first beat are on the outputs during cycle t+1.
  - Beats occupy cycles t+1 .. t+FRAME_LEN.
  - WAIT begins at cycle t+FRAME_LEN+1.
- out_valid sampled high at WAIT edge e:
  - done=1 in cycle e+1, with pass/got_result/counters already updated.
  - busy falls in cycle e+2, when start can first be accepted again.
- Timeout: with no out_valid, done rises at WAIT cycle TIMEOUT+1.
- Simultaneous events: out_valid on the same cycle the counter would reach TIMEOUT is accepted as a result; the result wins over the timeout.
- Reset asserted mid-frame (any state): at the next edge in_valid=0, the state is IDLE and the counters are cleared. A start on the first cycle after rst_n returns high is accepted.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 → all outputs 0, and no beat is issued while reset is held.
- Nominal, with frame_data=16'h4321, frame_mode=2'b01, exp_result=6'sd10:
  - in_number sequence is 1,2,3,4 on consecutive cycles; mode=01 on the first beat only.
  - The core model returns out_valid with 6'sd10 three cycles after the last beat.
  - Required: done one cycle later, pass=1, got_result=10, pass_cnt=1.
- Mismatch: exp_result=-5 (6'h3B), core returns 6'h05 → pass=0, got_result=5, fail_cnt=1, pass_cnt unchanged.
- Timeout: core silent → done exactly 17 cycles after WAIT entry, timeout=1, got_result=0, fail_cnt increments.
  - Variant: out_valid on the 16th WAIT cycle must give a normal result with timeout=0.
- Protocol slips: each of the following must leave busy timing and captured values unchanged.
  - start pulsed during SEND.
  - out_valid pulsed during SEND.
  - out_valid held high for 3 cycles with values 7, 9, 11 → got_result=7.
- Reset mid-frame and saturation:
  - rst_n=0 during beat 2 → in_valid=0 next cycle and counters 0; a fresh start then replays the frame from nibble 0.
  - Separately, 260 passing frames → pass_cnt stays at 255.
